// File: rtl/goldschmidt_ctrl.sv
// Sequential Goldschmidt divider for unsigned Q8.8 operands. One shared 48x32
// multiplier alternates between refining the divisor (MUL_D) and the numerator (MUL_N).
module goldschmidt_ctrl #(
    parameter int ITERS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] n,
    input  logic [15:0] d,
    output logic        busy,
    output logic        done,
    output logic [15:0] q,
    output logic        dbz,
    output logic [2:0]  state_dbg
);

    // Handshake: start is taken only while busy is low (IDLE); operands are latched
    // on that edge. done pulses for exactly one cycle with q/dbz valid, and busy is
    // already low in that cycle, so a new start may be presented alongside done.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NORM  = 3'd1,
        MUL_D = 3'd2,
        MUL_N = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic [3:0] ITERS_L = 4'(ITERS);

    state_t      state;
    state_t      state_next;
    logic [15:0] n_lat;
    logic [15:0] d_lat;
    logic [31:0] d_acc;
    logic [47:0] n_acc;
    logic [31:0] f_reg;
    logic [3:0]  cnt;

    logic [3:0]  lead_p;
    logic [4:0]  norm_sh;
    logic [31:0] f_calc;
    logic [47:0] mul_a;
    logic [31:0] mul_b;
    logic [79:0] mul_p;
    logic [47:0] mul_sh;
    logic [3:0]  cnt_inc;
    logic        sat;

    // Leading-one position of the latched divisor; d_lat is non-zero whenever NORM runs.
    always_comb begin
        lead_p = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (d_lat[i]) lead_p = 4'(i);
        end
    end

    assign norm_sh = 5'd30 - {1'b0, lead_p};

    // 2.0 - D in Q1.31 is the two's complement of D over 32 bits.
    assign f_calc  = 32'd0 - d_acc;
    assign mul_a   = (state == MUL_D) ? {16'd0, d_acc} : n_acc;
    assign mul_b   = (state == MUL_D) ? f_calc : f_reg;
    assign mul_p   = {32'd0, mul_a} * {48'd0, mul_b};
    assign mul_sh  = 48'(mul_p >> 31);
    assign cnt_inc = cnt + 4'd1;
    assign sat     = |n_acc[47:39];

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = (d == 16'd0) ? OUT : NORM;
            end
            NORM:    state_next = MUL_D;
            MUL_D:   state_next = MUL_N;
            MUL_N:   state_next = (cnt_inc < ITERS_L) ? MUL_D : OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_lat <= 16'd0;
            d_lat <= 16'd0;
            d_acc <= 32'd0;
            n_acc <= 48'd0;
            f_reg <= 32'd0;
            cnt   <= 4'd0;
            done  <= 1'b0;
            q     <= 16'h0000;
            dbz   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat <= n;
                        d_lat <= d;
                    end
                end
                NORM: begin
                    d_acc <= {16'd0, d_lat} << norm_sh;
                    n_acc <= {32'd0, n_lat} << norm_sh;
                    cnt   <= 4'd0;
                end
                MUL_D: begin
                    f_reg <= f_calc;
                    d_acc <= mul_sh[31:0];
                end
                MUL_N: begin
                    n_acc <= mul_sh;
                    cnt   <= cnt_inc;
                end
                OUT: begin
                    done <= 1'b1;
                    if (d_lat == 16'd0) begin
                        q   <= 16'hFFFF;
                        dbz <= 1'b1;
                    end else begin
                        q   <= sat ? 16'hFFFF : n_acc[38:23];
                        dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Directed bench for goldschmidt_ctrl: latency, quotient accuracy, divide-by-zero,
// saturation, start ignored while busy, back-to-back start and mid-operation reset.
module tb_goldschmidt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] n;
    logic [15:0] d;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic        dbz;
    logic [2:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    goldschmidt_ctrl #(.ITERS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n         (n),
        .d         (d),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .dbz       (dbz),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Called at the falling edge just after the edge that sampled start; lat counts
    // rising edges from that sampling edge until done is seen.
    task automatic wait_done(output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic run_div(input logic [15:0] nv, input logic [15:0] dv,
                           output int lat, output bit got);
        @(negedge clk);
        n = nv;
        d = dv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, got);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        n = 16'h1234;
        d = 16'h0001;
        repeat (3) @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (q !== 16'h0000) begin failures++; $display("FAIL reset_q got=%h exp=0000", q); end
        checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%0b exp=0", dbz); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_divide(input string name, input logic [15:0] nv, input logic [15:0] dv,
                               input logic [15:0] lo, input logic [15:0] hi);
        int lat;
        bit got;
        run_div(nv, dv, lat, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout no done within 40 edges", name);
        end else begin
            checks++; if (lat != 12) begin failures++; $display("FAIL %s_latency got=%0d exp=12", name, lat); end
            checks++; if (q < lo || q > hi) begin failures++; $display("FAIL %s_q got=%h exp=%h..%h", name, q, lo, hi); end
            checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL %s_dbz got=%0b exp=0", name, dbz); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_pulse done still high got=%0b exp=0", name, done); end
        end
    endtask

    task automatic test_dbz();
        int lat;
        bit got;
        run_div(16'h1234, 16'h0000, lat, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL dbz_timeout no done within 40 edges");
        end else begin
            checks++; if (lat != 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
            checks++; if (q !== 16'hFFFF) begin failures++; $display("FAIL dbz_q got=%h exp=ffff", q); end
            checks++; if (dbz !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%0b exp=1", dbz); end
            @(negedge clk);
            checks++; if (dbz !== 1'b1 || q !== 16'hFFFF) begin failures++; $display("FAIL dbz_hold got q=%h dbz=%0b exp q=ffff dbz=1", q, dbz); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit got;
        @(negedge clk);
        n = 16'h0700;
        d = 16'h0200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        n = 16'h0100;
        d = 16'h0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL b2b_first_timeout no done");
        end else begin
            checks++; if (lat + 4 != 12) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=12", lat + 4); end
            checks++; if (q < 16'h037F || q > 16'h0381) begin failures++; $display("FAIL b2b_first_q got=%h exp=037f..0381", q); end
            n = 16'h0900;
            d = 16'h0300;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_restart got done=%0b busy=%0b exp done=0 busy=1", done, busy); end
            wait_done(lat, got);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL b2b_second_timeout no done");
            end else begin
                checks++; if (lat != 12) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=12", lat); end
                checks++; if (q < 16'h02FF || q > 16'h0301) begin failures++; $display("FAIL b2b_second_q got=%h exp=02ff..0301", q); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit got;
        bit seen;
        @(negedge clk);
        n = 16'h0400;
        d = 16'h0200;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (state_dbg !== 3'd3) begin failures++; $display("FAIL midrst_in_mul_n got=%0d exp=3", state_dbg); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
        checks++; if (q !== 16'h0000) begin failures++; $display("FAIL midrst_q got=%h exp=0000", q); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done got=%0b exp=0", done); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL midrst_no_done got=1 exp=0"); end
        test_divide("midrst_after", 16'h0600, 16'h0300, 16'h01FF, 16'h0201);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        n = 16'h0000;
        d = 16'h0000;
        test_reset();
        test_divide("four_by_two", 16'h0400, 16'h0200, 16'h01FF, 16'h0201);
        test_divide("one_third", 16'h0100, 16'h0300, 16'h0054, 16'h0055);
        test_divide("three_by_half", 16'h0300, 16'h0080, 16'h05FF, 16'h0601);
        test_divide("tiny", 16'h0001, 16'hFFFF, 16'h0000, 16'h0001);
        test_divide("saturate", 16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF);
        test_dbz();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
